// File: rtl/vector_component_splitter.sv
// Vector component splitter: accepts a packed vector with a per-slot swizzle,
// then presents the swizzled components downstream either as one parallel beat
// or as NUM_COMP serial beats (one slot per beat, low bits, rest zero).
module vector_component_splitter #(
  parameter  int COMP_WIDTH = 16,
  parameter  int NUM_COMP   = 4,
  localparam int SEL_W      = $clog2(NUM_COMP)
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_COMP*COMP_WIDTH-1:0] in_vector,
  input  logic [NUM_COMP*SEL_W-1:0]      in_swizzle,
  input  logic                           in_mode,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_COMP*COMP_WIDTH-1:0] out_components,
  output logic [SEL_W-1:0]               out_idx,
  output logic                           out_last
);

  localparam int VEC_W = NUM_COMP * COMP_WIDTH;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_COMP - 1);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t                   state;
  logic [VEC_W-1:0]         slots_p0;
  logic                     mode_p0;
  logic [VEC_W-1:0]         swz_in;
  logic [SEL_W-1:0]         idx_next;
  logic                     accept;
  logic                     beat_done;

  // Pure bit routing: slot k takes the component named by its swizzle field.
  // Repeated indices broadcast one component to several slots.
  function automatic logic [VEC_W-1:0] swizzle(input logic [VEC_W-1:0]          vec,
                                               input logic [NUM_COMP*SEL_W-1:0] sel);
    logic [SEL_W-1:0] src;
    swizzle = '0;
    for (int k = 0; k < NUM_COMP; k++) begin
      src = sel[k*SEL_W +: SEL_W];
      swizzle[k*COMP_WIDTH +: COMP_WIDTH] = vec[int'(src)*COMP_WIDTH +: COMP_WIDTH];
    end
  endfunction

  // Serial beat: selected slot in the low component, upper components zero.
  function automatic logic [VEC_W-1:0] serial_beat(input logic [VEC_W-1:0] slots,
                                                   input logic [SEL_W-1:0] idx);
    serial_beat = '0;
    serial_beat[COMP_WIDTH-1:0] = slots[int'(idx)*COMP_WIDTH +: COMP_WIDTH];
  endfunction

  // Handshake qualifiers; a new vector may enter on the same edge the final
  // beat of the current one completes, so streaming has no bubble.
  always_comb begin
    in_ready  = reset_n && (!out_valid || (out_ready && out_last));
    accept    = in_valid && in_ready;
    beat_done = out_valid && out_ready;
    swz_in    = swizzle(in_vector, in_swizzle);
    idx_next  = out_idx + SEL_W'(1);
  end

  // Stage p0: swizzled slots of the accepted vector, kept for later serial beats.
  always_ff @(posedge clock) begin
    if (accept) slots_p0 <= swz_in;
  end

  // Control FSM with registered output beat; an accept takes priority over
  // returning to IDLE when both happen on the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      out_valid      <= 1'b0;
      out_components <= '0;
      out_idx        <= '0;
      out_last       <= 1'b0;
      mode_p0        <= 1'b0;
    end else if (accept) begin
      state          <= EMIT;
      out_valid      <= 1'b1;
      mode_p0        <= in_mode;
      out_idx        <= '0;
      out_last       <= !in_mode;
      out_components <= in_mode ? serial_beat(swz_in, '0) : swz_in;
    end else if (beat_done) begin
      if (out_last || !mode_p0) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end else begin
        out_idx        <= idx_next;
        out_last       <= (idx_next == LAST_IDX);
        out_components <= serial_beat(slots_p0, idx_next);
      end
    end
  end

endmodule
